// File: rtl/icache_pkg.sv
// Shared types, geometry constants and address helpers for the instruction-cache
// fill controller and its line buffer.
package icache_pkg;

    localparam int ASIZE  = 32;
    localparam int DSIZE  = 32;
    localparam int BBITS  = 5;
    localparam int BSIZE  = 8 << BBITS;
    localparam int BEATS  = BSIZE / DSIZE;
    localparam int CNTW   = 32;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [ASIZE-1:0] BLOCK_MASK = ~(ASIZE'((1 << BBITS) - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic logic [ASIZE-1:0] block_offset(input logic [ASIZE-1:0] addr);
        return addr & BLOCK_MASK;
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Assembles one cache block from memory beats; the first beat lands in the top
// word so the finished block matches the core's word-0-at-MSB layout.
module icache_line_buffer
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [DSIZE-1:0] beat_data,
    output logic             last,
    output logic [BSIZE-1:0] block
);

    logic [BEAT_W-1:0] count_q, count_d;
    logic [BSIZE-1:0]  block_q, block_d;

    always_comb begin
        count_d = count_q;
        block_d = block_q;
        if (clear) begin
            count_d = '0;
            block_d = '0;
        end else if (load) begin
            count_d = count_q + 1'b1;
            block_d = {block_q[BSIZE-DSIZE-1:0], beat_data};
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        block_q <= block_d;
    end

    assign last  = load && (count_q == BEAT_W'(BEATS - 1));
    assign block = block_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Sequencer in front of the direct-mapped instruction cache core: serves hits,
// fills blocks from memory on a miss, sequences invalidate-all and counts hits/misses.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cpu_req,
    input  logic [ASIZE-1:0] cpu_addr,
    input  logic             cpu_flush,
    output logic             cpu_ready,
    output logic [DSIZE-1:0] cpu_data,
    output logic             cpu_stall,
    output logic [ASIZE-1:0] core_addr,
    output logic             core_bread,
    output logic             core_bwrite,
    output logic [BSIZE-1:0] core_block_in,
    output logic             core_sys,
    input  logic             core_hit,
    input  logic [DSIZE-1:0] core_data,
    output logic             mem_req,
    output logic [ASIZE-1:0] mem_addr,
    input  logic             mem_valid,
    input  logic [DSIZE-1:0] mem_data,
    output logic [CNTW-1:0]  hit_count,
    output logic [CNTW-1:0]  miss_count
);

    state_e           state_q, state_d;
    logic [ASIZE-1:0] miss_addr_q, miss_addr_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNTW-1:0]  hit_count_q, hit_count_d;
    logic [CNTW-1:0]  miss_count_q, miss_count_d;
    logic             mem_req_q, mem_req_d;
    logic             core_bwrite_q, core_bwrite_d;
    logic             core_sys_q, core_sys_d;

    logic             in_idle;
    logic             buf_load;
    logic             buf_clear;
    logic             buf_last;
    logic [BSIZE-1:0] buf_block;

    assign in_idle   = (state_q == IDLE);
    assign buf_load  = mem_valid && (state_q == FILL);
    assign buf_clear = RESET || (state_q == WRITE);

    icache_line_buffer u_line_buffer (
        .clk       (CLK),
        .clear     (buf_clear),
        .load      (buf_load),
        .beat_data (mem_data),
        .last      (buf_last),
        .block     (buf_block)
    );

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                // A flush request outranks both hit and miss handling.
                if (cpu_flush) begin
                    state_d = FLUSH;
                end else if (cpu_req && core_hit) begin
                    hit_count_d = sat_inc(hit_count_q);
                end else if (cpu_req) begin
                    miss_addr_d  = cpu_addr;
                    miss_count_d = sat_inc(miss_count_q);
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (cpu_flush) flush_pend_d = 1'b1;
                if (buf_last)  state_d = WRITE;
            end
            WRITE: begin
                flush_pend_d = flush_pend_q || cpu_flush;
                state_d      = (flush_pend_q || cpu_flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mem_req_d     = (state_d == FILL);
        core_bwrite_d = (state_d == WRITE);
        core_sys_d    = (state_d == FLUSH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            miss_addr_q   <= '0;
            flush_pend_q  <= 1'b0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            mem_req_q     <= 1'b0;
            core_bwrite_q <= 1'b0;
            core_sys_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_addr_q   <= miss_addr_d;
            flush_pend_q  <= flush_pend_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            mem_req_q     <= mem_req_d;
            core_bwrite_q <= core_bwrite_d;
            core_sys_q    <= core_sys_d;
        end
    end

    assign cpu_ready     = in_idle && cpu_req && core_hit && !cpu_flush;
    assign cpu_data      = core_data;
    assign cpu_stall     = !in_idle || cpu_flush || (cpu_req && !core_hit);
    assign core_addr     = in_idle ? cpu_addr : miss_addr_q;
    assign core_bread    = cpu_req && in_idle;
    assign core_bwrite   = core_bwrite_q;
    assign core_block_in = buf_block;
    assign core_sys      = core_sys_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = block_offset(miss_addr_q);
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a small behavioural model of the cache core.
module tb_icache_fill_ctrl;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         cpu_req = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic         cpu_flush = 1'b0;
    logic         cpu_ready;
    logic [31:0]  cpu_data;
    logic         cpu_stall;
    logic [31:0]  core_addr;
    logic         core_bread;
    logic         core_bwrite;
    logic [255:0] core_block_in;
    logic         core_sys;
    logic         core_hit;
    logic [31:0]  core_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid = 1'b0;
    logic [31:0]  mem_data = '0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    icache_fill_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_flush     (cpu_flush),
        .cpu_ready     (cpu_ready),
        .cpu_data      (cpu_data),
        .cpu_stall     (cpu_stall),
        .core_addr     (core_addr),
        .core_bread    (core_bread),
        .core_bwrite   (core_bwrite),
        .core_block_in (core_block_in),
        .core_sys      (core_sys),
        .core_hit      (core_hit),
        .core_data     (core_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Direct-mapped core model: 16 lines of 256 bits, word 0 in bits [255:224].
    logic [255:0] mdl_data [16];
    logic [22:0]  mdl_tag [16];
    logic [15:0]  mdl_valid = '0;
    logic         mdl_clr = 1'b0;
    logic         mdl_pre = 1'b0;
    logic [31:0]  pre_addr = '0;
    logic [255:0] pre_block = '0;
    logic [3:0]   lk_idx;
    logic [2:0]   lk_word;

    always @(posedge CLK) begin
        if (mdl_clr || core_sys) begin
            mdl_valid <= '0;
        end else if (core_bwrite) begin
            mdl_valid[core_addr[8:5]] <= 1'b1;
            mdl_tag[core_addr[8:5]]   <= core_addr[31:9];
            mdl_data[core_addr[8:5]]  <= core_block_in;
        end else if (mdl_pre) begin
            mdl_valid[pre_addr[8:5]] <= 1'b1;
            mdl_tag[pre_addr[8:5]]   <= pre_addr[31:9];
            mdl_data[pre_addr[8:5]]  <= pre_block;
        end
    end

    always_comb begin
        lk_idx    = core_addr[8:5];
        lk_word   = core_addr[4:2];
        core_hit  = mdl_valid[lk_idx] && (mdl_tag[lk_idx] == core_addr[31:9]);
        core_data = mdl_data[lk_idx][255 - 32 * int'(lk_word) -: 32];
    end

    int overlap_cnt = 0;
    always @(negedge CLK) begin
        if (!RESET && (int'(core_sys) + int'(core_bwrite) + int'(mem_req) > 1))
            overlap_cnt <= overlap_cnt + 1;
    end

    // Observations gathered by drive_fill, checked by the calling test.
    int           ob_stall, ob_bw_cnt, ob_bw_cyc, ob_sys_cnt, ob_sys_cyc;
    int           ob_ready_cyc, ob_last_req_cyc;
    logic         ob_post_ready, ob_post_stall;
    logic [255:0] ob_block;
    logic [31:0]  ob_bw_addr, ob_mem_addr, ob_data;

    // Presents a missing fetch and feeds the block beat by beat (beat k = word k of blk).
    task automatic drive_fill(input logic [31:0] addr, input int gap, input logic [255:0] blk,
                              input int flush_cyc, input bit junk0);
        int beat;
        int next_beat_cyc;
        ob_stall = 0; ob_bw_cnt = 0; ob_bw_cyc = -1; ob_sys_cnt = 0; ob_sys_cyc = -1;
        ob_ready_cyc = -1; ob_last_req_cyc = -1; ob_post_ready = 1'bx; ob_post_stall = 1'bx;
        ob_block = '0; ob_bw_addr = '0; ob_mem_addr = '0; ob_data = '0;
        beat = 0;
        next_beat_cyc = 1;
        cpu_req = 1'b1;
        cpu_addr = addr;
        for (int cyc = 0; cyc < 60; cyc++) begin
            mem_valid = 1'b0;
            mem_data = '0;
            if (cyc == 0 && junk0) begin
                mem_valid = 1'b1;
                mem_data = 32'hBAD0_BAD0;
            end
            if (beat < 8 && cyc == next_beat_cyc) begin
                mem_valid = 1'b1;
                mem_data = blk[255 - 32 * beat -: 32];
                beat++;
                next_beat_cyc = cyc + 1 + gap;
            end
            cpu_flush = (cyc == flush_cyc);
            #1;
            if (ob_sys_cyc >= 0 && cyc == ob_sys_cyc + 1) begin
                ob_post_ready = cpu_ready;
                ob_post_stall = cpu_stall;
                break;
            end
            if (cpu_stall) ob_stall++;
            if (mem_req) begin
                ob_last_req_cyc = cyc;
                ob_mem_addr = mem_addr;
            end
            if (core_bwrite) begin
                ob_bw_cnt++;
                ob_bw_cyc = cyc;
                ob_block = core_block_in;
                ob_bw_addr = core_addr;
            end
            if (core_sys) begin
                ob_sys_cnt++;
                ob_sys_cyc = cyc;
            end
            if (cpu_ready) begin
                ob_ready_cyc = cyc;
                ob_data = cpu_data;
                break;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        mem_valid = 1'b0;
        cpu_flush = 1'b0;
        if (ob_ready_cyc >= 0) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        mdl_clr = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 32'h0040_0020;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        cpu_req = 1'b0;
        mdl_clr = 1'b0;
        mdl_pre = 1'b1;
        pre_addr = 32'h0040_0020;
        pre_block = {32'h2402_0005, 224'd0};
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        vectors++; if (core_bwrite !== 1'b0) begin miscompares++; $display("FAIL reset_bwrite: got %b expected 0", core_bwrite); end
        vectors++; if (core_sys !== 1'b0) begin miscompares++; $display("FAIL reset_sys: got %b expected 0", core_sys); end
        vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin miscompares++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_count, miss_count); end
        vectors++; if (core_block_in !== 256'd0) begin miscompares++; $display("FAIL reset_block_in: got %h expected 0", core_block_in); end
        vectors++; if (mem_addr !== 32'd0 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_addr_stall: got %h/%b expected 0/0", mem_addr, cpu_stall); end
        @(posedge CLK);
        @(negedge CLK);
        mdl_pre = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_hit();
        cpu_req = 1'b1;
        cpu_addr = 32'h0040_0020;
        #1;
        vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL hit_ready: got %b expected 1", cpu_ready); end
        vectors++; if (cpu_data !== 32'h2402_0005) begin miscompares++; $display("FAIL hit_data: got %h expected 24020005", cpu_data); end
        vectors++; if (core_bread !== 1'b1 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL hit_bread_stall: got %b/%b expected 1/0", core_bread, cpu_stall); end
        @(posedge CLK);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        vectors++; if (hit_count !== 32'd1) begin miscompares++; $display("FAIL hit_count: got %0d expected 1", hit_count); end
        vectors++; if (mem_req !== 1'b0 || miss_count !== 32'd0) begin miscompares++; $display("FAIL hit_no_fill: got %b/%0d expected 0/0", mem_req, miss_count); end
    endtask

    task automatic test_cold_miss();
        logic [255:0] blk;
        blk = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        drive_fill(32'h0040_0044, 1, blk, -1, 1'b0);
        vectors++; if (ob_mem_addr !== 32'h0040_0040) begin miscompares++; $display("FAIL cold_mem_addr: got %h expected 00400040", ob_mem_addr); end
        vectors++; if (ob_bw_cnt !== 1 || ob_bw_cyc !== 16) begin miscompares++; $display("FAIL cold_bwrite: got %0d pulses at cycle %0d expected 1 at 16", ob_bw_cnt, ob_bw_cyc); end
        vectors++; if (ob_block !== blk) begin miscompares++; $display("FAIL cold_block: got %h expected %h", ob_block, blk); end
        vectors++; if (ob_bw_addr !== 32'h0040_0044) begin miscompares++; $display("FAIL cold_bw_addr: got %h expected 00400044", ob_bw_addr); end
        vectors++; if (ob_last_req_cyc !== 15) begin miscompares++; $display("FAIL cold_mem_req_end: got %0d expected 15", ob_last_req_cyc); end
        vectors++; if (ob_ready_cyc !== 17 || ob_data !== 32'h2222_2222) begin miscompares++; $display("FAIL cold_relookup: got cycle %0d data %h expected 17 22222222", ob_ready_cyc, ob_data); end
        vectors++; if (miss_count !== 32'd1 || hit_count !== 32'd2) begin miscompares++; $display("FAIL cold_counters: got %0d/%0d expected miss 1 hit 2", miss_count, hit_count); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] blk;
        blk = 256'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007;
        drive_fill(32'h0040_0104, 0, blk, -1, 1'b1);
        vectors++; if (ob_bw_cyc !== 9 || ob_last_req_cyc !== 8) begin miscompares++; $display("FAIL b2b_write_timing: got write %0d req_end %0d expected 9/8", ob_bw_cyc, ob_last_req_cyc); end
        vectors++; if (ob_stall !== 10) begin miscompares++; $display("FAIL b2b_stall: got %0d expected 10", ob_stall); end
        vectors++; if (ob_block !== blk) begin miscompares++; $display("FAIL b2b_block: got %h expected %h", ob_block, blk); end
        vectors++; if (ob_ready_cyc !== 10 || ob_data !== 32'hA000_0001) begin miscompares++; $display("FAIL b2b_relookup: got cycle %0d data %h expected 10 a0000001", ob_ready_cyc, ob_data); end
        vectors++; if (miss_count !== 32'd2 || hit_count !== 32'd3) begin miscompares++; $display("FAIL b2b_counters: got %0d/%0d expected miss 2 hit 3", miss_count, hit_count); end
    endtask

    task automatic test_flush_during_fill();
        logic [255:0] blk;
        blk = 256'h5A000000_5A000001_5A000002_5A000003_5A000004_5A000005_5A000006_5A000007;
        drive_fill(32'h0040_01A8, 0, blk, 4, 1'b0);
        vectors++; if (ob_bw_cnt !== 1 || ob_bw_cyc !== 9) begin miscompares++; $display("FAIL flfill_bwrite: got %0d at %0d expected 1 at 9", ob_bw_cnt, ob_bw_cyc); end
        vectors++; if (ob_block !== blk) begin miscompares++; $display("FAIL flfill_block: got %h expected %h", ob_block, blk); end
        vectors++; if (ob_sys_cnt !== 1 || ob_sys_cyc !== 10) begin miscompares++; $display("FAIL flfill_sys: got %0d at %0d expected 1 at 10", ob_sys_cnt, ob_sys_cyc); end
        vectors++; if (ob_post_ready !== 1'b0 || ob_post_stall !== 1'b1) begin miscompares++; $display("FAIL flfill_refetch_miss: got ready %b stall %b expected 0/1", ob_post_ready, ob_post_stall); end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        vectors++; if (mem_req !== 1'b0 || miss_count !== 32'd3) begin miscompares++; $display("FAIL flfill_idle: got req %b misses %0d expected 0/3", mem_req, miss_count); end
    endtask

    task automatic test_flush_idle();
        int sys_pulses;
        sys_pulses = 0;
        cpu_req = 1'b1;
        cpu_addr = 32'h0040_0104;
        cpu_flush = 1'b1;
        #1;
        vectors++; if (cpu_ready !== 1'b0 || cpu_stall !== 1'b1) begin miscompares++; $display("FAIL flidle_ready: got %b/%b expected 0/1", cpu_ready, cpu_stall); end
        @(posedge CLK);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        if (core_sys) sys_pulses++;
        vectors++; if (core_sys !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL flidle_sys: got sys %b req %b expected 1/0", core_sys, mem_req); end
        @(posedge CLK);
        @(negedge CLK);
        cpu_flush = 1'b0;
        #1;
        if (core_sys) sys_pulses++;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (core_sys) sys_pulses++;
        vectors++; if (sys_pulses !== 1) begin miscompares++; $display("FAIL flidle_absorb: got %0d pulses expected 1", sys_pulses); end
        vectors++; if (miss_count !== 32'd3 || hit_count !== 32'd3) begin miscompares++; $display("FAIL flidle_counters: got %0d/%0d expected 3/3", miss_count, hit_count); end
    endtask

    task automatic test_reset_mid_fill();
        logic [255:0] blk;
        int bw_seen;
        bw_seen = 0;
        cpu_req = 1'b1;
        cpu_addr = 32'h0040_0080;
        for (int cyc = 0; cyc < 7; cyc++) begin
            mem_valid = (cyc >= 1);
            mem_data = 32'hDEAD_0000 + 32'(cyc);
            RESET = (cyc == 6);
            @(posedge CLK);
            @(negedge CLK);
        end
        RESET = 1'b0;
        mem_valid = 1'b0;
        cpu_req = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0 || core_bwrite !== 1'b0 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_fill_idle: got req %b bw %b stall %b expected 0/0/0", mem_req, core_bwrite, cpu_stall); end
        vectors++; if (miss_count !== 32'd0 || hit_count !== 32'd0) begin miscompares++; $display("FAIL rst_fill_counters: got %0d/%0d expected 0/0", miss_count, hit_count); end
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            #1;
            if (core_bwrite || mem_req) bw_seen++;
        end
        vectors++; if (bw_seen !== 0) begin miscompares++; $display("FAIL rst_fill_quiet: got %0d active cycles expected 0", bw_seen); end
        blk = 256'hC0000000_C0000001_C0000002_C0000003_C0000004_C0000005_C0000006_C0000007;
        drive_fill(32'h0040_0080, 0, blk, -1, 1'b0);
        vectors++; if (ob_block !== blk || ob_bw_cnt !== 1) begin miscompares++; $display("FAIL rst_fill_block: got %h (%0d) expected %h (1)", ob_block, ob_bw_cnt, blk); end
        vectors++; if (ob_bw_cyc !== 9 || ob_stall !== 10) begin miscompares++; $display("FAIL rst_fill_timing: got write %0d stall %0d expected 9/10", ob_bw_cyc, ob_stall); end
        vectors++; if (ob_data !== 32'hC000_0000 || miss_count !== 32'd1) begin miscompares++; $display("FAIL rst_fill_relookup: got %h misses %0d expected c0000000/1", ob_data, miss_count); end
    endtask

    task automatic test_saturation();
        force dut.hit_count_q = 32'hFFFF_FFFE;
        @(posedge CLK);
        @(negedge CLK);
        release dut.hit_count_q;
        #1;
        vectors++; if (hit_count !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sat_preset: got %h expected fffffffe", hit_count); end
        cpu_req = 1'b1;
        cpu_addr = 32'h0040_0084;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (cpu_ready !== 1'b1 || cpu_data !== 32'hC000_0001) begin miscompares++; $display("FAIL sat_hit%0d: got %b %h expected 1 c0000001", i, cpu_ready, cpu_data); end
            @(posedge CLK);
            @(negedge CLK);
            #1;
            vectors++; if (hit_count !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sat_count%0d: got %h expected ffffffff", i, hit_count); end
        end
        cpu_req = 1'b0;
        vectors++; if (miss_count !== 32'd1) begin miscompares++; $display("FAIL sat_misses: got %0d expected 1", miss_count); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_hit();
        test_cold_miss();
        test_back_to_back();
        test_flush_during_fill();
        test_flush_idle();
        test_reset_mid_fill();
        test_saturation();
        @(negedge CLK);
        vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL exclusive_strobes: got %0d overlapping cycles expected 0", overlap_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Sequencing controller for the direct-mapped instruction cache core (256-bit blocks, 32-bit address).
- Serves CPU fetches on a hit.
- On a miss, stalls the CPU, fetches the block from memory as 8 word beats, assembles it, writes it into the core with a one-cycle bwrite, then re-looks-up.
- Sequences flush (the core's SYS invalidate).
- Keeps hit/miss counters.

Parameters:
ASIZE, 32, address width
DSIZE, 32, word/beat width
BBITS, 5, block offset bits
BSIZE, 256, block width (8<<BBITS)
BEATS, 8, BSIZE/DSIZE beats per fill
CNTW, 32, perf counter width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
cpu_req  in  1  fetch request
cpu_addr  in  ASIZE  fetch address
cpu_flush  in  1  invalidate-all request (pulse)
cpu_ready  out  1  fetch completes this cycle, cpu_data valid
cpu_data  out  DSIZE  fetched word
cpu_stall  out  1  miss or flush in progress
core_addr  out  ASIZE  to core address1
core_bread  out  1  to core bread (=cpu_req in IDLE)
core_bwrite  out  1  to core bwrite
core_block_in  out  BSIZE  to core block_in
core_sys  out  1  to core SYS (invalidate pulse)
core_hit  in  1  from core hit1
core_data  in  DSIZE  from core data_out1
mem_req  out  1  block read request, held until last beat
mem_addr  out  ASIZE  block-aligned address (low BBITS zero)
mem_valid  in  1  one beat on mem_data this cycle
mem_data  in  DSIZE  beat data
hit_count  out  CNTW  saturating hit counter
miss_count  out  CNTW  saturating miss counter

Behaviour:
- Reset (RESET=1 at posedge):
  - state=IDLE, beat counter=0, flush_pend=0, counters=0.
  - All registered outputs 0; core_block_in=0.
  - Reset mid-fill abandons the fill: mem_req drops the next cycle and the core is not written.
- States: IDLE, FILL, WRITE, FLUSH.
- core_addr:
  - In IDLE: cpu_addr.
  - In FILL and WRITE: the latched miss address miss_addr.
- IDLE:
  - cpu_ready = cpu_req & core_hit (combinational, zero-latency hit); cpu_data = core_data.
  - Hit: hit_count+1.
  - cpu_req & ~core_hit: latch miss_addr=cpu_addr, miss_count+1, cpu_stall=1, go FILL.
  - cpu_flush (with or without req) takes priority over the miss: go FLUSH, no counter update, cpu_ready=0.
- FILL:
  - mem_req=1; mem_addr={miss_addr[ASIZE-1:BBITS], BBITS'b0}; cpu_stall=1; cpu_ready=0.
  - Each mem_valid cycle stores mem_data into the buffer, MSB-first: beat k -> bits [BSIZE-1-32k : BSIZE-32k-DSIZE]. Beat 0 is bits [255:224], matching the core's word-0 layout.
  - Beat counter increments per beat. On the beat where counter==BEATS-1, go WRITE; mem_req=0 from the next cycle.
  - mem_valid while not in FILL is ignored.
  - cpu_addr/cpu_req changes during FILL are ignored.
  - cpu_flush during FILL or WRITE sets flush_pend.
- WRITE:
  - core_bwrite=1 for exactly one cycle; core_block_in=assembled buffer; core_addr=miss_addr.
  - Beat counter cleared; cpu_stall=1.
  - Next: FLUSH if flush_pend, else IDLE.
  - Back in IDLE the CPU re-presents the request, the core hits, and cpu_ready rises. Miss-to-ready latency = 1 + beats + mem latency + 1 cycles.
- FLUSH:
  - core_sys=1 for one cycle; cpu_stall=1; flush_pend cleared; go IDLE.
  - A flush arriving while in FLUSH is absorbed (no second pulse).
- Counters saturate at all-ones and do not wrap.
- core_bread = cpu_req & (state==IDLE).
- core_sys, core_bwrite and mem_req are never asserted together.

Decomposition:
- Shared package icache_pkg holds:
  - state enum (IDLE/FILL/WRITE/FLUSH);
  - constants ASIZE/DSIZE/BBITS/BSIZE/BEATS;
  - a block_offset(addr) helper that aligns an address to its block.
- One natural sub-module, icache_line_buffer: beat counter plus the MSB-first shift/insert register. Its interface is clear, load, beat data, last flag, and block out.
- The FSM and counters stay in the top module.

Test Plan:
- Hit after reset: preload the core so that 0x0040_0020 hits with data 0x2402_0005; cpu_req -> cpu_ready=1 and cpu_data=0x24020005 in the same cycle, hit_count=1, no mem_req.
- Cold miss at 0x0040_0044: mem_addr=0x0040_0040; beats 0x11111111..0x88888888 with 1-cycle gaps -> core_bwrite one cycle with core_block_in=0x11111111_22222222_..._88888888. The re-lookup then gives cpu_data=0x22222222 (offset 4), and miss_count=1.
- Back-to-back beats, no gaps: 8 consecutive mem_valid cycles -> WRITE on the cycle after beat 8; mem_req low from that cycle; total stall is exactly 10 cycles.
- Flush during fill: cpu_flush at beat 3 -> fill completes, then core_bwrite, then core_sys the next cycle, then IDLE; the first fetch afterwards misses.
- Reset mid-fill: RESET at beat 5 -> state IDLE, mem_req=0, no core_bwrite. A later miss to the same address restarts at beat 0, and the assembled block contains only the new beats.
- Counter saturation: force hit_count to 0xFFFF_FFFE, then issue 3 hits -> hit_count stays at 0xFFFF_FFFF.
